// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the random stop-select reaction timer.
//   state_e    : round FSM states
//   LFSR_TAPS  : feedback tap mask of the 16-bit Fibonacci LFSR (bits 15,13,12,10)
//   MS_W       : width of every millisecond count
//   lfsr_next  : one LFSR step (shift left, parity of tapped bits enters at bit 0)
//   code_onehot: 3-bit select code to 8-bit one-hot prompt pattern
// ---------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PROMPT = 3'd2,
        DONE   = 3'd3,
        FOUL   = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          MS_W      = 14;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] code_onehot(input logic [2:0] code);
        return 8'h01 << code;
    endfunction

endpackage

// File: rtl/random_stop_arbiter_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, one step per clock, maximal length
// (period 65535). Reset loads SEED, which must be nonzero so the register
// never enters the all-zero lock-up state.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   q    out  current LFSR value
// ---------------------------------------------------------------------------
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: one Fibonacci step every cycle.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/random_stop_arbiter.sv
// ---------------------------------------------------------------------------
// random_stop_arbiter
// Producer side of the random stop-select path. Each rising edge of `start`
// begins a round: a pseudo-random source code and wait are drawn from the
// LFSR, the code is driven to the stop-source mux on `lfsrout`, and after the
// wait the matching prompt LED lights. The number of whole milliseconds until
// the selected source (`stop_in`, the mux output) rises is reported on
// `react_ms`. A rise before the prompt is a false start (FOUL).
//
// Optional feature macro: BEST_TIME_EN adds `best_ms`, the lowest completed
// reaction time since reset (FOUL rounds never update it).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   start     in   round request level; acted on at its rising edge
//   stop_in   in   selected stop source, asynchronous (2-flop synchronized)
//   lfsrout   out  3-bit mux select code, stable for the whole round
//   prompt    out  one-hot "press this" LEDs, bit n for code n
//   busy      out  high in ARM and PROMPT
//   done      out  high in DONE
//   foul      out  high in FOUL
//   react_ms  out  measured reaction time, saturates at MAX_MS
//   best_ms   out  (BEST_TIME_EN only) best reaction time, reset MAX_MS
// ---------------------------------------------------------------------------
module random_stop_arbiter
    import reaction_pkg::*;
#(
    parameter int          CLK_PER_MS  = 50000,
    parameter int          MIN_WAIT_MS = 1000,
    parameter int          RAND_BITS   = 10,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          MAX_MS      = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop_in,
    output logic [2:0]  lfsrout,
    output logic [7:0]  prompt,
    output logic        busy,
    output logic        done,
    output logic        foul,
    output logic [13:0] react_ms
`ifdef BEST_TIME_EN
    ,
    output logic [13:0] best_ms
`endif
);

    localparam int DIV_W  = $clog2(CLK_PER_MS + 1);
    localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS) + 1);

    logic [15:0]       lfsr_q;
    logic              unused_lfsr_s;

    state_e            state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [WAIT_W-1:0] wait_q,    wait_d;
    logic [MS_W-1:0]   react_q,   react_d;
    logic [2:0]        lfsrout_q, lfsrout_d;
    logic [7:0]        prompt_q,  prompt_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              foul_q,    foul_d;

    // Two synchronizer stages plus a "previous" stage per async input.
    logic [2:0]        start_sync_q, start_sync_d;
    logic [2:0]        stop_sync_q,  stop_sync_d;

    logic              start_rise_s;
    logic              stop_rise_s;
    logic              tick_s;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low LFSR bits feed the draw; the rest are folded away here.
    assign unused_lfsr_s = ^lfsr_q;

    // Synchronizer shift chains for start and stop_in.
    always_comb begin
        start_sync_d = {start_sync_q[1:0], start};
        stop_sync_d  = {stop_sync_q[1:0],  stop_in};
    end

    // Edge detection on the synchronized levels; tick on divider wrap.
    always_comb begin
        start_rise_s = start_sync_q[1] & ~start_sync_q[2];
        stop_rise_s  = stop_sync_q[1]  & ~stop_sync_q[2];
        tick_s       = (div_q == DIV_W'(CLK_PER_MS - 1));
    end

    // Round FSM: next state, round registers and registered outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        react_d   = react_q;
        lfsrout_d = lfsrout_q;
        prompt_d  = prompt_q;

        case (state_q)
            IDLE, DONE, FOUL: begin
                prompt_d = 8'h00;
                if (start_rise_s) begin
                    state_d   = ARM;
                    lfsrout_d = lfsr_q[2:0];
                    wait_d    = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[RAND_BITS+2:3]);
                    react_d   = {MS_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ARM: begin
                // A false start outranks a wait expiring in the same cycle.
                if (stop_rise_s) begin
                    state_d = FOUL;
                end else if (tick_s) begin
                    // Expiry on the tick that would take the wait to 0, so
                    // ARM lasts exactly wait_ms milliseconds.
                    if (wait_q <= WAIT_W'(1)) begin
                        state_d  = PROMPT;
                        prompt_d = code_onehot(lfsrout_q);
                        wait_d   = {WAIT_W{1'b0}};
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end else begin
                    wait_d = wait_q;
                end
            end
            PROMPT: begin
                // The stop edge wins over a coincident tick: count frozen.
                if (stop_rise_s) begin
                    state_d  = DONE;
                    prompt_d = 8'h00;
                end else if (tick_s && (react_q < MS_W'(MAX_MS))) begin
                    react_d = react_q + MS_W'(1);
                end else begin
                    react_d = react_q;
                end
            end
            default: begin
                state_d  = IDLE;
                prompt_d = 8'h00;
            end
        endcase
    end

    // Output flags follow the next state so they line up with state_q.
    always_comb begin
        busy_d = (state_d == ARM) || (state_d == PROMPT);
        done_d = (state_d == DONE);
        foul_d = (state_d == FOUL);
    end

    // Millisecond divider, restarted on every state change.
    always_comb begin
        if (state_d != state_q) begin
            div_d = {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State, counters, synchronizers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= {DIV_W{1'b0}};
            wait_q       <= {WAIT_W{1'b0}};
            react_q      <= {MS_W{1'b0}};
            lfsrout_q    <= 3'd0;
            prompt_q     <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            foul_q       <= 1'b0;
            start_sync_q <= 3'b000;
            stop_sync_q  <= 3'b000;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            wait_q       <= wait_d;
            react_q      <= react_d;
            lfsrout_q    <= lfsrout_d;
            prompt_q     <= prompt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            foul_q       <= foul_d;
            start_sync_q <= start_sync_d;
            stop_sync_q  <= stop_sync_d;
        end
    end

    assign lfsrout  = lfsrout_q;
    assign prompt   = prompt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign foul     = foul_q;
    assign react_ms = react_q;

`ifdef BEST_TIME_EN
    logic [MS_W-1:0] best_q, best_d;

    // Best time updates only on a completed round that beats the record.
    always_comb begin
        if ((state_q == PROMPT) && (state_d == DONE) && (react_q < best_q)) begin
            best_d = react_q;
        end else begin
            best_d = best_q;
        end
    end

    // Best-time register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= MS_W'(MAX_MS);
        end else begin
            best_q <= best_d;
        end
    end

    assign best_ms = best_q;
`endif

endmodule
